// File: rtl/secure_fsm_pkg.sv
// Shared state encodings, command codes and the state legality check
// used by the secure privilege-mode controller.
package secure_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_USER   = 3'b001,
        ST_SUPER  = 3'b010,
        ST_DEBUG  = 3'b100,
        ST_LOCKED = 3'b111
    } state_e;

    localparam int CMD_NOP   = 0;
    localparam int CMD_EXIT  = 1;
    localparam int CMD_USER  = 2;
    localparam int CMD_SUPER = 3;
    localparam int CMD_DEBUG = 4;

    // Codes 011, 101 and 110 can only appear through an upset.
    function automatic logic is_legal_state(input logic [2:0] s);
        case (s)
            ST_IDLE, ST_USER, ST_SUPER, ST_DEBUG, ST_LOCKED: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_lock_timer.sv
// Lockout down-counter: load starts a LOCK_CYCLES countdown, expire is high
// in the last locked cycle. LOCK_CYCLES=0 never expires.
module fsm_lock_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int TW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LOAD_VAL;
        end else if (count_q != '0) begin
            count_q <= count_q - TW'(1);
        end
    end

    // With a zero length the count never leaves 0, so expiry stays low.
    assign expire = (LOCK_CYCLES != 0) && (count_q == TW'(1));

endmodule

// File: rtl/secure_mode_fsm.sv
// Command-driven privilege-mode controller with authorisation gating,
// reject counting, timed lockout and recovery from illegal state codes.
module secure_mode_fsm
    import secure_fsm_pkg::*;
#(
    parameter int CMD_W       = 3,
    parameter int FAULT_LIMIT = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int CNT_W       = $clog2(FAULT_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    input  logic [CMD_W-1:0] cmd_i,
    input  logic             auth_ok_i,
    input  logic             debug_en_i,
    output logic             cmd_ready_o,
    output logic [2:0]       mode_o,
    output logic             priv_o,
    output logic             dbg_access_o,
    output logic             locked_o,
    output logic             reject_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    // Handshake: a command transfers on a rising edge where cmd_valid_i and
    // cmd_ready_o are both high; ready depends only on registered state.

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FAULT_LIMIT);
    localparam logic [CMD_W-1:0] C_NOP   = CMD_W'(CMD_NOP);
    localparam logic [CMD_W-1:0] C_EXIT  = CMD_W'(CMD_EXIT);
    localparam logic [CMD_W-1:0] C_USER  = CMD_W'(CMD_USER);
    localparam logic [CMD_W-1:0] C_SUPER = CMD_W'(CMD_SUPER);
    localparam logic [CMD_W-1:0] C_DEBUG = CMD_W'(CMD_DEBUG);

    logic [2:0]       state_q, state_d;
    logic             reject_q, reject_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             legal, accept;
    logic             timer_load, timer_expire;
    logic             move;
    logic [2:0]       move_to;

    assign legal       = is_legal_state(state_q);
    assign cmd_ready_o = legal && (state_q != ST_LOCKED);
    assign accept      = cmd_valid_i && cmd_ready_o;

    fsm_lock_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .expire(timer_expire)
    );

    // Legal transition table; anything without a hit here is a reject.
    always_comb begin
        move    = 1'b0;
        move_to = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_i == C_USER) begin
                    move    = 1'b1;
                    move_to = ST_USER;
                end else if ((cmd_i == C_SUPER) && auth_ok_i) begin
                    move    = 1'b1;
                    move_to = ST_SUPER;
                end else if (cmd_i == C_EXIT) begin
                    move    = 1'b1;
                    move_to = ST_IDLE;
                end
            end
            ST_USER: begin
                if ((cmd_i == C_SUPER) && auth_ok_i) begin
                    move    = 1'b1;
                    move_to = ST_SUPER;
                end else if (cmd_i == C_EXIT) begin
                    move    = 1'b1;
                    move_to = ST_IDLE;
                end
            end
            ST_SUPER: begin
                if ((cmd_i == C_DEBUG) && debug_en_i) begin
                    move    = 1'b1;
                    move_to = ST_DEBUG;
                end else if (cmd_i == C_EXIT) begin
                    move    = 1'b1;
                    move_to = ST_USER;
                end
            end
            ST_DEBUG: begin
                if (cmd_i == C_EXIT) begin
                    move    = 1'b1;
                    move_to = ST_SUPER;
                end
            end
            default: begin
                move    = 1'b0;
                move_to = state_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        reject_d   = 1'b0;
        fault_d    = 1'b0;
        cnt_d      = cnt_q;
        timer_load = 1'b0;
        if (!legal) begin
            state_d    = ST_LOCKED;
            fault_d    = 1'b1;
            timer_load = 1'b1;
        end else if (state_q == ST_LOCKED) begin
            if (timer_expire) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if (accept && (cmd_i != C_NOP)) begin
            if (move) begin
                state_d = move_to;
            end else begin
                reject_d = 1'b1;
                cnt_d    = (cnt_q >= LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
                // The reject that reaches the limit locks instead of staying.
                if (cnt_d == LIMIT) begin
                    state_d    = ST_LOCKED;
                    timer_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            reject_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            reject_q <= reject_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mode_o       = state_q;
    assign priv_o       = (state_q == ST_SUPER) || (state_q == ST_DEBUG);
    assign dbg_access_o = (state_q == ST_DEBUG);
    assign locked_o     = !legal || (state_q == ST_LOCKED);
    assign reject_o     = reject_q;
    assign fault_o      = fault_q;
    assign fault_cnt_o  = cnt_q;

endmodule
